key_state_tracker: RTL

Sequential successor to the combinational key-code mapper. Consumes the raw PS/2 scan-code byte stream, parses make, break (F0) and extended (E0) prefixes, and keeps a held-key register for six tracked keys. From that register it produces the 4-bit direction code, fire and jump levels, and one-shot fire/jump pulses that typematic repeats do not retrigger. Sits between the PS/2 receiver and the player-control logic.

---
 rtl/key_state_tracker_if.sv | 21 ++
 rtl/key_state_tracker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/key_state_tracker_if.sv
// Scan-byte strobe in, resolved player-control levels and pulses out.
interface key_state_tracker_if;
  logic       scan_valid;
  logic [7:0] scan_code;
  logic [3:0] dir_code;
  logic       fire;
  logic       jump;
  logic       fire_pulse;
  logic       jump_pulse;
  logic [2:0] held_count;

  modport master (
    output scan_valid, scan_code,
    input  dir_code, fire, jump, fire_pulse, jump_pulse, held_count
  );

  modport slave (
    input  scan_valid, scan_code,
    output dir_code, fire, jump, fire_pulse, jump_pulse, held_count
  );
endinterface

// File: rtl/key_state_tracker.sv
// PS/2 make/break/extended parser holding six tracked keys; outputs registered, 2 cycles after the strobe.
// Accepts a byte every cycle (no backpressure); KEY_TIMEOUT_EN adds an idle timeout that releases all keys.
module key_state_tracker #(
  parameter bit ARROW_EN       = 1'b1,
  parameter int TIMEOUT_CYCLES = 60_000_000
) (
  input logic             Clk,
  input logic             Reset,
  key_state_tracker_if.slave kbd
);

  localparam int KW = 0;
  localparam int KA = 1;
  localparam int KS = 2;
  localparam int KD = 3;
  localparam int KJ = 4;
  localparam int KK = 5;

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} parseState_e;

  parseState_e stateQ, stateD;
  logic [5:0]  baseKey, arrowKey;
  logic [5:0]  setMask, clrMask;
  logic [5:0]  heldQ;
  logic        lastV, lastH;
  logic        freshJ, freshK;
  logic        timeoutHit;

  logic        vUp, vDown, hLeft, hRight;
  logic [3:0]  dirNext;
  logic [2:0]  popCount;

  logic [3:0]  dirQ;
  logic        fireQ, jumpQ, firePulseQ, jumpPulseQ;
  logic [2:0]  heldCountQ;

  // Key decode for plain and E0-prefixed codes
  always_comb begin
    baseKey = '0;
    case (kbd.scan_code)
      8'h1D:   baseKey[KW] = 1'b1;
      8'h1C:   baseKey[KA] = 1'b1;
      8'h1B:   baseKey[KS] = 1'b1;
      8'h23:   baseKey[KD] = 1'b1;
      8'h3B:   baseKey[KJ] = 1'b1;
      8'h42:   baseKey[KK] = 1'b1;
      default: baseKey = '0;
    endcase
    arrowKey = '0;
    if (ARROW_EN) begin
      case (kbd.scan_code)
        8'h75:   arrowKey[KW] = 1'b1;
        8'h6B:   arrowKey[KA] = 1'b1;
        8'h72:   arrowKey[KS] = 1'b1;
        8'h74:   arrowKey[KD] = 1'b1;
        default: arrowKey = '0;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) stateQ <= IDLE;
    else       stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    if (timeoutHit) begin
      stateD = IDLE;
    end else if (kbd.scan_valid) begin
      case (stateQ)
        IDLE: begin
          if (kbd.scan_code == 8'hF0)      stateD = BRK;
          else if (kbd.scan_code == 8'hE0) stateD = EXT;
        end
        BRK: begin
          if (kbd.scan_code != 8'hF0) stateD = IDLE;
        end
        EXT: begin
          if (kbd.scan_code == 8'hF0)      stateD = EXT_BRK;
          else if (kbd.scan_code != 8'hE0) stateD = IDLE;
        end
        default: stateD = IDLE;
      endcase
    end
  end

  // Prefix bytes never decode as keys, so masks need no extra byte qualification
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (kbd.scan_valid) begin
      case (stateQ)
        IDLE:    setMask = baseKey;
        BRK:     clrMask = baseKey;
        EXT:     setMask = arrowKey;
        default: clrMask = arrowKey;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      heldQ  <= '0;
      lastV  <= 1'b0;
      lastH  <= 1'b0;
      freshJ <= 1'b0;
      freshK <= 1'b0;
    end else begin
      freshJ <= setMask[KJ] & ~heldQ[KJ];
      freshK <= setMask[KK] & ~heldQ[KK];
      if (timeoutHit) begin
        heldQ <= '0;
        lastV <= 1'b0;
        lastH <= 1'b0;
      end else begin
        heldQ <= (heldQ | setMask) & ~clrMask;
        // lastV/lastH: 0 means W/A was the latest make, 1 means S/D
        if (setMask[KW]) lastV <= 1'b0;
        if (setMask[KS]) lastV <= 1'b1;
        if (setMask[KA]) lastH <= 1'b0;
        if (setMask[KD]) lastH <= 1'b1;
      end
    end
  end

`ifdef KEY_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] idleCnt;

  assign timeoutHit = !kbd.scan_valid && (heldQ != '0) &&
                      (idleCnt == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                              idleCnt <= '0;
    else if (kbd.scan_valid || heldQ == '0 || timeoutHit)   idleCnt <= '0;
    else                                                    idleCnt <= idleCnt + 1'b1;
  end
`else
  assign timeoutHit = 1'b0;
`endif

  always_comb begin
    vUp    = heldQ[KW] & (~heldQ[KS] | ~lastV);
    vDown  = heldQ[KS] & (~heldQ[KW] |  lastV);
    hLeft  = heldQ[KA] & (~heldQ[KD] | ~lastH);
    hRight = heldQ[KD] & (~heldQ[KA] |  lastH);
    if (vUp)        dirNext = hLeft ? 4'd5 : (hRight ? 4'd6 : 4'd1);
    else if (vDown) dirNext = hLeft ? 4'd7 : (hRight ? 4'd8 : 4'd3);
    else            dirNext = hLeft ? 4'd2 : (hRight ? 4'd4 : 4'd0);
    popCount = '0;
    for (int i = 0; i < 6; i++) popCount = popCount + 3'(heldQ[i]);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      dirQ       <= '0;
      fireQ      <= 1'b0;
      jumpQ      <= 1'b0;
      firePulseQ <= 1'b0;
      jumpPulseQ <= 1'b0;
      heldCountQ <= '0;
    end else begin
      dirQ       <= dirNext;
      fireQ      <= heldQ[KJ];
      jumpQ      <= heldQ[KK];
      firePulseQ <= freshJ;
      jumpPulseQ <= freshK;
      heldCountQ <= popCount;
    end
  end

  assign kbd.dir_code   = dirQ;
  assign kbd.fire       = fireQ;
  assign kbd.jump       = jumpQ;
  assign kbd.fire_pulse = firePulseQ;
  assign kbd.jump_pulse = jumpPulseQ;
  assign kbd.held_count = heldCountQ;

endmodule
